// File: rtl/cic_pkg.sv
// Shared definitions for the variable-ratio CIC decimator: register map, reset defaults,
// AHB address-phase payload and the accumulator-width helper.
package cic_pkg;

    localparam int unsigned DW_DEF    = 16;
    localparam int unsigned N_DEF     = 4;
    localparam int unsigned RMAX_DEF  = 256;

    localparam int unsigned SHIFT_W   = 6;
    localparam int unsigned RATIO_RST = 16;
    localparam int unsigned SHIFT_RST = 16;
    localparam logic        EN_RST    = 1'b1;

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_RATIO  = 2'd1,
        REG_SHIFT  = 2'd2,
        REG_STATUS = 2'd3
    } reg_sel_e;

    // AHB address phase as held through the following data phase
    typedef struct packed {
        logic     valid;
        logic     write;
        logic     mapped;
        reg_sel_e sel;
    } ahb_aphase_t;

    function automatic int unsigned cic_aw(input int unsigned dw, input int unsigned n,
                                           input int unsigned rmax);
        return dw + n * $clog2(rmax);
    endfunction

endpackage

// File: rtl/cic_ahb_regs.sv
// AHB-Lite slave and register bank for the CIC decimator: CTRL.EN, RATIO, SHIFT, STATUS.
// flush_c pulses in the cycle a RATIO write or an EN 0->1 write takes effect.
module cic_ahb_regs
    import cic_pkg::*;
#(
    parameter int unsigned DW   = DW_DEF,
    parameter int unsigned N    = N_DEF,
    parameter int unsigned RMAX = RMAX_DEF
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [31:0]              haddr,
    input  logic [1:0]               htrans,
    input  logic [31:0]              hwdata,
    input  logic                     hwrite,
    input  logic                     hsel,
    output logic [31:0]              hrdata,
    output logic                     hreadyout,
    output logic                     hresp,
    output logic                     en,
    output logic [$clog2(RMAX):0]    ratio,
    output logic [SHIFT_W-1:0]       shift,
    output logic                     flush_c
);

    localparam int unsigned RW = $clog2(RMAX) + 1;

    ahb_aphase_t         aph_d, aph_q;
    logic                wr_c;
    logic                en_d;
    logic [RW-1:0]       ratio_d;
    logic [RW-1:0]       wr_ratio_c;
    logic [SHIFT_W-1:0]  shift_d;
    logic [31:0]         rd_d;
    logic                unused_c;

    assign hreadyout = 1'b1;
    assign hresp     = 1'b0;
    assign unused_c  = ^{hwdata[31:RW], htrans[0], haddr[31:8], haddr[1:0]};

    // Decoded window is 256 bytes; only the first four words are mapped
    always_comb begin
        aph_d.valid  = hsel & htrans[1] & hreadyout;
        aph_d.write  = hwrite;
        aph_d.mapped = (haddr[7:4] == 4'd0);
        aph_d.sel    = reg_sel_e'(haddr[3:2]);
    end

    assign wr_c       = aph_q.valid & aph_q.write & aph_q.mapped;
    assign wr_ratio_c = hwdata[RW-1:0];

    // Next register values; reads use these so a read right after a write sees the new value
    always_comb begin
        en_d    = en;
        ratio_d = ratio;
        shift_d = shift;
        flush_c = 1'b0;
        if (wr_c) begin
            case (aph_q.sel)
                REG_CTRL: begin
                    en_d    = hwdata[0];
                    flush_c = hwdata[0] & ~en;
                end
                REG_RATIO: begin
                    if (wr_ratio_c == '0)
                        ratio_d = RW'(1);
                    else if (wr_ratio_c > RW'(RMAX))
                        ratio_d = RW'(RMAX);
                    else
                        ratio_d = wr_ratio_c;
                    flush_c = 1'b1;
                end
                REG_SHIFT: shift_d = hwdata[SHIFT_W-1:0];
                default:   ;
            endcase
        end
    end

    always_comb begin
        rd_d = '0;
        if (aph_d.valid & ~aph_d.write & aph_d.mapped) begin
            case (aph_d.sel)
                REG_CTRL:   rd_d = 32'(en_d);
                REG_RATIO:  rd_d = 32'(ratio_d);
                REG_SHIFT:  rd_d = 32'(shift_d);
                REG_STATUS: rd_d = {8'd0, 8'(N), 16'(DW)};
                default:    rd_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            aph_q  <= '0;
            en     <= EN_RST;
            ratio  <= RW'(RATIO_RST);
            shift  <= SHIFT_W'(SHIFT_RST);
            hrdata <= '0;
        end else begin
            aph_q  <= aph_d;
            en     <= en_d;
            ratio  <= ratio_d;
            shift  <= shift_d;
            hrdata <= rd_d;
        end
    end

endmodule

// File: rtl/cic_decimator_variable_ahb.sv
// N-stage CIC decimator (M=1) with run-time ratio, AXI-Stream in/out and AHB-Lite control.
// Output is the comb result arithmetically shifted right by SHIFT and saturated to DW bits.
module cic_decimator_variable_ahb
    import cic_pkg::*;
#(
    parameter int unsigned DW   = DW_DEF,
    parameter int unsigned N    = N_DEF,
    parameter int unsigned RMAX = RMAX_DEF
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            ce,
    input  logic [DW-1:0]   tdata_s,
    input  logic            tvalid_s,
    output logic            tready_s,
    output logic [DW-1:0]   tdata_m,
    output logic            tvalid_m,
    input  logic            tready_m,
    input  logic [31:0]     haddr_s,
    input  logic [2:0]      hburst_s,
    input  logic [2:0]      hsize_s,
    input  logic [1:0]      htrans_s,
    input  logic [31:0]     hwdata_s,
    input  logic            hwrite_s,
    output logic [31:0]     hrdata_s,
    output logic            hreadyout_s,
    output logic            hresp_s,
    input  logic            hsel_s
);

    localparam int unsigned AW = cic_aw(DW, N, RMAX);
    localparam int unsigned RW = $clog2(RMAX) + 1;

    logic                  en;
    logic [RW-1:0]         ratio;
    logic [SHIFT_W-1:0]    shift;
    logic                  flush_c;
    logic                  unused_c;

    logic signed [AW-1:0]  integ_q    [N];
    logic signed [AW-1:0]  integ_d    [N];
    logic signed [AW-1:0]  comb_dly_q [N];
    logic signed [AW-1:0]  comb_x     [N+1];
    logic signed [AW-1:0]  shifted_c;
    logic [AW-DW:0]        top_bits_c;
    logic [DW-1:0]         sat_c;
    logic [RW-1:0]         cnt_q;
    logic                  accept_c;
    logic                  dump_c;

    assign unused_c = ^{hburst_s, hsize_s};

    cic_ahb_regs #(
        .DW   (DW),
        .N    (N),
        .RMAX (RMAX)
    ) u_regs (
        .clk       (clk),
        .reset_n   (reset_n),
        .haddr     (haddr_s),
        .htrans    (htrans_s),
        .hwdata    (hwdata_s),
        .hwrite    (hwrite_s),
        .hsel      (hsel_s),
        .hrdata    (hrdata_s),
        .hreadyout (hreadyout_s),
        .hresp     (hresp_s),
        .en        (en),
        .ratio     (ratio),
        .shift     (shift),
        .flush_c   (flush_c)
    );

    assign tready_s = ce & en & ~(tvalid_m & ~tready_m);
    assign accept_c = tvalid_s & tready_s;
    assign dump_c   = accept_c & (cnt_q == ratio - RW'(1));

    // Integrator chain: each stage adds the previous stage's registered value
    always_comb begin
        integ_d[0] = integ_q[0] + {{(AW-DW){tdata_s[DW-1]}}, tdata_s};
        for (int k = 1; k < N; k++) begin
            integ_d[k] = integ_q[k] + integ_q[k-1];
        end
    end

    // Comb chain fed by the integrator value that includes the R-th sample
    always_comb begin
        comb_x[0] = integ_d[N-1];
        for (int k = 0; k < N; k++) begin
            comb_x[k+1] = comb_x[k] - comb_dly_q[k];
        end
    end

    // Saturate when the bits above the DW-1 sign bit are not a pure sign extension
    always_comb begin
        shifted_c  = comb_x[N] >>> shift;
        top_bits_c = shifted_c[AW-1:DW-1];
        if ((&top_bits_c) | ~(|top_bits_c))
            sat_c = shifted_c[DW-1:0];
        else if (shifted_c[AW-1])
            sat_c = {1'b1, {(DW-1){1'b0}}};
        else
            sat_c = {1'b0, {(DW-1){1'b1}}};
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            for (int k = 0; k < N; k++) begin
                integ_q[k]    <= '0;
                comb_dly_q[k] <= '0;
            end
            cnt_q    <= '0;
            tvalid_m <= 1'b0;
            tdata_m  <= '0;
        end else if (flush_c) begin
            for (int k = 0; k < N; k++) begin
                integ_q[k]    <= '0;
                comb_dly_q[k] <= '0;
            end
            cnt_q    <= '0;
            tvalid_m <= 1'b0;
        end else if (ce) begin
            if (accept_c) begin
                for (int k = 0; k < N; k++) begin
                    integ_q[k] <= integ_d[k];
                end
                cnt_q <= dump_c ? '0 : cnt_q + RW'(1);
            end
            if (dump_c) begin
                for (int k = 0; k < N; k++) begin
                    comb_dly_q[k] <= comb_x[k];
                end
                tdata_m  <= sat_c;
                tvalid_m <= 1'b1;
            end else if (tready_m) begin
                tvalid_m <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cic_decimator_variable_ahb.sv
// Directed bench for cic_decimator_variable_ahb: register access, DC gain at several ratios,
// backpressure, clock-enable freeze and output saturation.
module tb_cic_decimator_variable_ahb;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        ce = 1'b1;
    logic [15:0] tdata_s = '0;
    logic        tvalid_s = 1'b0;
    logic        tready_s;
    logic [15:0] tdata_m;
    logic        tvalid_m;
    logic        tready_m = 1'b1;
    logic [31:0] haddr_s = '0;
    logic [2:0]  hburst_s = '0;
    logic [2:0]  hsize_s = 3'd2;
    logic [1:0]  htrans_s = '0;
    logic [31:0] hwdata_s = '0;
    logic        hwrite_s = 1'b0;
    logic [31:0] hrdata_s;
    logic        hreadyout_s;
    logic        hresp_s;
    logic        hsel_s = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    int acc_cnt = 0;
    int bus_err = 0;
    int outq[$];

    cic_decimator_variable_ahb dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ce          (ce),
        .tdata_s     (tdata_s),
        .tvalid_s    (tvalid_s),
        .tready_s    (tready_s),
        .tdata_m     (tdata_m),
        .tvalid_m    (tvalid_m),
        .tready_m    (tready_m),
        .haddr_s     (haddr_s),
        .hburst_s    (hburst_s),
        .hsize_s     (hsize_s),
        .htrans_s    (htrans_s),
        .hwdata_s    (hwdata_s),
        .hwrite_s    (hwrite_s),
        .hrdata_s    (hrdata_s),
        .hreadyout_s (hreadyout_s),
        .hresp_s     (hresp_s),
        .hsel_s      (hsel_s)
    );

    always #5 clk = ~clk;

    // Handshakes seen on the falling edge complete on the following rising edge
    always @(negedge clk) begin
        if (!reset_n) begin
            if (tvalid_s && tready_s) acc_cnt++;
            if (ce && tvalid_m && tready_m) outq.push_back(int'(signed'(tdata_m)));
            if (hresp_s !== 1'b0 || hreadyout_s !== 1'b1) bus_err++;
        end
    end

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
        hsel_s = 1'b1; htrans_s = 2'b10; hwrite_s = 1'b1; haddr_s = a;
        @(posedge clk); #1;
        hsel_s = 1'b0; htrans_s = 2'b00; hwrite_s = 1'b0; hwdata_s = d;
        @(posedge clk); #1;
    endtask

    task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
        hsel_s = 1'b1; htrans_s = 2'b10; hwrite_s = 1'b0; haddr_s = a;
        @(posedge clk); #1;
        hsel_s = 1'b0; htrans_s = 2'b00;
        d = hrdata_s;
        @(posedge clk); #1;
    endtask

    // Write immediately followed by a read of the same address
    task automatic ahb_write_read(input logic [31:0] a, input logic [31:0] wd,
                                  output logic [31:0] rd);
        hsel_s = 1'b1; htrans_s = 2'b10; hwrite_s = 1'b1; haddr_s = a;
        @(posedge clk); #1;
        hwrite_s = 1'b0; hwdata_s = wd;
        @(posedge clk); #1;
        hsel_s = 1'b0; htrans_s = 2'b00;
        rd = hrdata_s;
        @(posedge clk); #1;
    endtask

    task automatic send_dc(input int val, input int n);
        int target;
        int budget;
        target = acc_cnt + n;
        budget = n * 4 + 100;
        tdata_s  = 16'(val);
        tvalid_s = 1'b1;
        while (acc_cnt < target && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        tvalid_s = 1'b0;
        check_eq("send_accepted", acc_cnt, target);
    endtask

    task automatic check_dc(input string tag, input int n_out, input int val, input int skip);
        check_eq({tag, "_count"}, outq.size(), n_out);
        for (int i = skip; i < outq.size() && i < n_out; i++) begin
            check_eq(tag, outq[i], val);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int acc0;

        reset_n = 1'b1;
        idle(10);
        reset_n = 1'b0;
        idle(1);
        check_eq("rst_tvalid_m", tvalid_m, 0);
        check_eq("rst_tdata_m", tdata_m, 0);
        check_eq("rst_hrdata", hrdata_s, 0);
        check_eq("rst_tready_s", tready_s, 1);
        ahb_read(32'h0, rd);  check_eq("rst_ctrl", rd, 1);
        ahb_read(32'h4, rd);  check_eq("rst_ratio", rd, 16);
        ahb_read(32'h8, rd);  check_eq("rst_shift", rd, 16);
        ahb_read(32'hC, rd);  check_eq("rst_status", rd, 32'h0004_0010);

        // DC 1000, R=16, SHIFT=16: unity gain, one output per 16 inputs, one-cycle latency
        outq.delete();
        send_dc(1000, 16);
        check_eq("r16_latency_tvalid", tvalid_m, 1);
        send_dc(1000, 176);
        idle(3);
        check_dc("r16_dc1000", 12, 1000, 5);

        // RATIO write clamping and write-then-read forwarding
        ahb_write(32'h4, 32'd300);
        ahb_read(32'h4, rd);  check_eq("ratio_clamp_max", rd, 256);
        ahb_write(32'h4, 32'd0);
        ahb_read(32'h4, rd);  check_eq("ratio_clamp_min", rd, 1);
        ahb_write_read(32'h8, 32'd0, rd);
        check_eq("shift_fwd_read", rd, 0);

        // R=1, SHIFT=0: output tracks input after the pipeline transient
        outq.delete();
        send_dc(123, 10);
        idle(3);
        check_dc("r1_dc123", 10, 123, 5);

        // R=4, SHIFT=8, DC -2000
        ahb_write(32'h4, 32'd4);
        ahb_write(32'h8, 32'd8);
        ahb_read(32'h4, rd);  check_eq("ratio_rb4", rd, 4);
        ahb_read(32'h8, rd);  check_eq("shift_rb8", rd, 8);
        outq.delete();
        send_dc(-2000, 60);
        idle(3);
        check_dc("r4_dcm2000", 15, -2000, 5);

        // Backpressure: stalls after the first pending output, nothing lost or duplicated
        ahb_write(32'h4, 32'd4);
        outq.delete();
        acc0 = acc_cnt;
        tready_m = 1'b0;
        tdata_s  = 16'(-2000);
        tvalid_s = 1'b1;
        idle(50);
        check_eq("bp_accepted", acc_cnt - acc0, 4);
        check_eq("bp_tready_s", tready_s, 0);
        check_eq("bp_tvalid_m", tvalid_m, 1);
        check_eq("bp_no_output", outq.size(), 0);
        tready_m = 1'b1;
        send_dc(-2000, 36);
        idle(3);
        check_dc("bp_dcm2000", 10, -2000, 5);

        // ce=0 freezes with the 6th (steady) output pending
        ahb_write(32'h4, 32'd4);
        outq.delete();
        send_dc(-2000, 24);
        ce = 1'b0;
        acc0 = acc_cnt;
        tvalid_s = 1'b1;
        idle(20);
        check_eq("ce0_tready_s", tready_s, 0);
        check_eq("ce0_accepted", acc_cnt - acc0, 0);
        check_eq("ce0_tvalid_m", tvalid_m, 1);
        check_eq("ce0_tdata_m", int'(signed'(tdata_m)), -2000);
        check_eq("ce0_out_count", outq.size(), 5);
        ahb_read(32'h4, rd);  check_eq("ce0_ahb_read", rd, 4);
        tvalid_s = 1'b0;
        ce = 1'b1;
        send_dc(-2000, 16);
        idle(3);
        check_dc("ce_resume", 10, -2000, 5);

        // EN gates input acceptance
        ahb_write(32'h0, 32'd0);
        check_eq("en0_tready_s", tready_s, 0);
        ahb_read(32'h0, rd);  check_eq("en0_ctrl", rd, 0);
        ahb_write(32'h0, 32'd1);
        check_eq("en1_tready_s", tready_s, 1);

        // SHIFT=0 with full-scale DC saturates positive
        ahb_write(32'h4, 32'd4);
        ahb_write(32'h8, 32'd0);
        outq.delete();
        send_dc(32767, 40);
        idle(3);
        check_dc("sat_pos", 10, 32767, 5);

        ahb_read(32'h20, rd); check_eq("unmapped_read", rd, 0);
        check_eq("hresp_always_okay", bus_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
